// File: rtl/rv_ctl_mc.sv
// rv_ctl_mc: multicycle RISC-V control plane.
// Sequences FETCH/DECODE/execute states for the shared multicycle datapath,
// with a ready-qualified memory handshake, a per-access wait timeout that
// traps, illegal-instruction flagging and a retired-instruction counter.
module rv_ctl_mc #(
    parameter int unsigned RETIRE_W   = 32,
    parameter bit          BRANCH_EXT = 1'b1,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                zero,
    input  logic                lt,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                memrw,
    output logic                pcsource,
    output logic                pcwrite,
    output logic                pccen,
    output logic                irwrite,
    output logic                regwen,
    output logic                bsel,
    output logic                mdrwrite,
    output logic                datawsel,
    output logic                addrsel,
    output logic [1:0]          wbsel,
    output logic [1:0]          immsel,
    output logic [1:0]          asel,
    output logic [3:0]          alusel,
    output logic                illegal,
    output logic                timeout,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_dbg
);

    // Datapath select encodings shared with the multicycle datapath
    localparam logic       PC_INC    = 1'b0;
    localparam logic       PC_ALU    = 1'b1;
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd0;
    localparam logic [1:0] IMM_S     = 2'd1;
    localparam logic [1:0] IMM_B     = 2'd2;
    localparam logic [1:0] IMM_J     = 2'd3;
    localparam logic [1:0] ALUA_REG  = 2'd0;
    localparam logic [1:0] ALUA_PCC  = 2'd1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_LSW_ADDR  = 4'd2,
        S_LW_MEM    = 4'd3,
        S_LW_WB     = 4'd4,
        S_SW_MEM    = 4'd5,
        S_RTYPE_ALU = 4'd6,
        S_ITYPE_ALU = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BR_EXEC   = 4'd9,
        S_JAL_EXEC  = 4'd10,
        S_JALR_EXEC = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [7:0]          wait_cnt;
    logic [RETIRE_W-1:0] retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       dec_lw, dec_sw, dec_r, dec_i, dec_br, dec_jal, dec_jalr;
    logic       mem_state, wait_trap, retire_now;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Instruction classification from the held IR contents
    always_comb begin
        dec_lw   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
        dec_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
        dec_r    = (opcode == OP_RTYPE);
        dec_i    = (opcode == OP_ITYPE);
        dec_jal  = (opcode == OP_JAL);
        dec_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);
        dec_br   = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:                 dec_br = 1'b1;
                3'b001, 3'b100, 3'b101: dec_br = BRANCH_EXT;
                default:                dec_br = 1'b0;
            endcase
        end
    end

    assign mem_state  = (state == S_FETCH) || (state == S_LW_MEM) || (state == S_SW_MEM);
    assign wait_trap  = mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);
    assign retire_now = (state == S_LW_WB) || (state == S_ALU_WB) ||
                        (state == S_BR_EXEC) || (state == S_JAL_EXEC) ||
                        (state == S_JALR_EXEC) || ((state == S_SW_MEM) && mem_ready);

    // Next-state selection; a wait overflow overrides the normal transition
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:     if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (dec_lw || dec_sw) state_nx = S_LSW_ADDR;
                else if (dec_r)       state_nx = S_RTYPE_ALU;
                else if (dec_i)       state_nx = S_ITYPE_ALU;
                else if (dec_br)      state_nx = S_BR_EXEC;
                else if (dec_jal)     state_nx = S_JAL_EXEC;
                else if (dec_jalr)    state_nx = S_JALR_EXEC;
                else                  state_nx = S_FETCH;
            end
            S_LSW_ADDR:  state_nx = dec_sw ? S_SW_MEM : S_LW_MEM;
            S_LW_MEM:    if (mem_ready) state_nx = S_LW_WB;
            S_LW_WB:     state_nx = S_FETCH;
            S_SW_MEM:    if (mem_ready) state_nx = S_FETCH;
            S_RTYPE_ALU: state_nx = S_ALU_WB;
            S_ITYPE_ALU: state_nx = S_ALU_WB;
            S_ALU_WB:    state_nx = S_FETCH;
            S_BR_EXEC:   state_nx = S_FETCH;
            S_JAL_EXEC:  state_nx = S_FETCH;
            S_JALR_EXEC: state_nx = S_FETCH;
            S_TRAP:      state_nx = S_TRAP;
            default:     state_nx = S_FETCH;
        endcase
        if (wait_trap) state_nx = S_TRAP;
    end

    // State, wait counter, sticky timeout and retired counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_trap)
                timeout <= 1'b1;
            if (retire_now)
                retired_q <= retired_q + 1'b1;
        end
    end

    // Datapath controls; held at defaults while rst is asserted so nothing writes
    always_comb begin
        mem_req  = 1'b0;
        memrw    = 1'b0;
        pcsource = PC_INC;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        bsel     = ALUB_REG;
        mdrwrite = 1'b0;
        datawsel = 1'b0;
        addrsel  = 1'b0;
        wbsel    = WB_PC;
        immsel   = IMM_B;
        asel     = ALUA_REG;
        alusel   = ALU_ADD;
        illegal  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    irwrite = mem_ready;
                    pccen   = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    asel    = ALUA_PCC;
                    bsel    = ALUB_IMM;
                    immsel  = IMM_B;
                    illegal = !(dec_lw || dec_sw || dec_r || dec_i ||
                                dec_br || dec_jal || dec_jalr);
                end
                S_LSW_ADDR: begin
                    bsel   = ALUB_IMM;
                    immsel = dec_sw ? IMM_S : IMM_L;
                end
                S_LW_MEM: begin
                    mem_req  = 1'b1;
                    mdrwrite = mem_ready;
                end
                S_LW_WB: begin
                    wbsel  = WB_MDR;
                    regwen = 1'b1;
                end
                S_SW_MEM: begin
                    mem_req = 1'b1;
                    memrw   = 1'b1;
                end
                S_RTYPE_ALU: alusel = {funct3, instr[30]};
                S_ITYPE_ALU: begin
                    bsel   = ALUB_IMM;
                    immsel = IMM_L;
                    alusel = (funct3 == 3'b101) ? {funct3, instr[30]} : {funct3, 1'b0};
                end
                S_ALU_WB: begin
                    wbsel  = WB_ALUOUT;
                    regwen = 1'b1;
                end
                S_BR_EXEC: begin
                    alusel   = ALU_SUB;
                    pcsource = PC_ALU;
                    case (funct3)
                        3'b000:  pcwrite = zero;
                        3'b001:  pcwrite = !zero;
                        3'b100:  pcwrite = lt;
                        3'b101:  pcwrite = !lt;
                        default: pcwrite = 1'b0;
                    endcase
                end
                S_JAL_EXEC: begin
                    immsel   = IMM_J;
                    asel     = ALUA_PCC;
                    bsel     = ALUB_IMM;
                    pcsource = PC_ALU;
                    pcwrite  = 1'b1;
                    regwen   = 1'b1;
                    wbsel    = WB_PC;
                end
                S_JALR_EXEC: begin
                    immsel   = IMM_L;
                    asel     = ALUA_REG;
                    bsel     = ALUB_IMM;
                    pcsource = PC_ALU;
                    pcwrite  = 1'b1;
                    regwen   = 1'b1;
                    wbsel    = WB_PC;
                end
                default: ;
            endcase
        end
    end

    assign retired   = retired_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_rv_ctl_mc.sv
// Self-checking bench for rv_ctl_mc: directed scenarios plus randomized
// instructions checked against an instruction-level reference model.
module tb_rv_ctl_mc;

    localparam int MAXW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst, zero, lt, mem_ready;
    logic [31:0] instr;
    logic        mem_req, memrw, pcsource, pcwrite, pccen, irwrite, regwen, bsel;
    logic        mdrwrite, datawsel, addrsel, illegal, timeout;
    logic [1:0]  wbsel, immsel, asel;
    logic [3:0]  alusel, state_dbg;
    logic [31:0] retired;

    // Instance B: 4-bit retired counter, base branch set only
    logic        rst_b, mem_ready_b;
    logic [31:0] instr_b;
    logic        b_mem_req, b_memrw, b_pcsource, b_pcwrite, b_pccen, b_irwrite, b_regwen, b_bsel;
    logic        b_mdrwrite, b_datawsel, b_addrsel, b_illegal, b_timeout;
    logic [1:0]  b_wbsel, b_immsel, b_asel;
    logic [3:0]  b_alusel, b_state_dbg, b_retired;

    rv_ctl_mc #(.RETIRE_W(32), .BRANCH_EXT(1'b1), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .memrw(memrw), .pcsource(pcsource), .pcwrite(pcwrite),
        .pccen(pccen), .irwrite(irwrite), .regwen(regwen), .bsel(bsel),
        .mdrwrite(mdrwrite), .datawsel(datawsel), .addrsel(addrsel),
        .wbsel(wbsel), .immsel(immsel), .asel(asel), .alusel(alusel),
        .illegal(illegal), .timeout(timeout), .retired(retired), .state_dbg(state_dbg)
    );

    rv_ctl_mc #(.RETIRE_W(4), .BRANCH_EXT(1'b0), .MAX_WAIT(MAXW)) dut_b (
        .clk(clk), .rst(rst_b), .instr(instr_b), .zero(zero), .lt(lt), .mem_ready(mem_ready_b),
        .mem_req(b_mem_req), .memrw(b_memrw), .pcsource(b_pcsource), .pcwrite(b_pcwrite),
        .pccen(b_pccen), .irwrite(b_irwrite), .regwen(b_regwen), .bsel(b_bsel),
        .mdrwrite(b_mdrwrite), .datawsel(b_datawsel), .addrsel(b_addrsel),
        .wbsel(b_wbsel), .immsel(b_immsel), .asel(b_asel), .alusel(b_alusel),
        .illegal(b_illegal), .timeout(b_timeout), .retired(b_retired), .state_dbg(b_state_dbg)
    );

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_ret = '0;
    logic [3:0]  exp_ret_b = '0;

    // Per-cycle observation log of instance A for the current instruction
    logic [3:0] ob_state [64];
    logic [3:0] ob_alu   [64];
    bit         ob_pcw [64], ob_rw [64], ob_mdr [64], ob_ill [64], ob_st [64], ob_bsel [64];
    int         ob_n;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0040A283;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_ADDI = 32'h00500093;

    // Drive one instruction into A and log every cycle until FETCH is re-entered
    task automatic run_a(input logic [31:0] ins, input int fw, input int mw,
                         input logic z, input logic l, output bit done);
        int wd;
        bit left;
        wd = 0; left = 0; done = 0; ob_n = 0;
        instr = ins; zero = z; lt = l;
        for (int c = 0; c < 64; c++) begin
            if (mem_req) begin
                if (wd < ((state_dbg == 4'd0) ? fw : mw)) begin mem_ready = 1'b0; wd++; end
                else begin mem_ready = 1'b1; wd = 0; end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            ob_state[ob_n] = state_dbg; ob_alu[ob_n] = alusel;
            ob_pcw[ob_n] = pcwrite; ob_rw[ob_n] = regwen; ob_mdr[ob_n] = mdrwrite;
            ob_ill[ob_n] = illegal; ob_st[ob_n] = mem_req & memrw; ob_bsel[ob_n] = bsel;
            ob_n++;
            @(posedge clk); #1;
            if (state_dbg != 4'd0) left = 1;
            else if (left) begin done = 1; break; end
        end
    endtask

    // Drive one instruction into B with memory always ready
    task automatic run_b(input logic [31:0] ins, output int cyc, output int ill, output bit done);
        bit left;
        left = 0; cyc = 0; ill = 0; done = 0;
        instr_b = ins; mem_ready_b = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            cyc++;
            if (b_illegal) ill++;
            @(posedge clk); #1;
            if (b_state_dbg != 4'd0) left = 1;
            else if (left) begin done = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1; mem_ready = 1'b1; mem_ready_b = 1'b1;
        zero = 1'b0; lt = 1'b0; instr = I_ADD; instr_b = I_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({mem_req, memrw, pcsource, pcwrite, pccen, irwrite, regwen, bsel,
             mdrwrite, datawsel, addrsel, illegal} !== 12'h000) begin
            fails++; $display("FAIL reset_ctl1 got %03h want 000", {mem_req, memrw, pcsource, pcwrite,
                pccen, irwrite, regwen, bsel, mdrwrite, datawsel, addrsel, illegal});
        end
        tests_run++;
        if ({wbsel, immsel, asel, alusel} !== {2'd2, 2'd2, 2'd0, 4'd0}) begin
            fails++; $display("FAIL reset_sel got %03h want %03h", {wbsel, immsel, asel, alusel},
                {2'd2, 2'd2, 2'd0, 4'd0});
        end
        tests_run++;
        if ({state_dbg, timeout, retired} !== 37'h0) begin
            fails++; $display("FAIL reset_state got st=%0d to=%0b ret=%0d want 0", state_dbg, timeout, retired);
        end
        tests_run++;
        if ({b_state_dbg, b_retired, b_mem_req} !== 9'h0) begin
            fails++; $display("FAIL reset_b got st=%0d ret=%0d req=%0b want 0", b_state_dbg, b_retired, b_mem_req);
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
    endtask

    task automatic test_b_ext0_and_wrap();
        int cyc, ill;
        bit done;
        logic [31:0] ins;
        run_b(I_BNE, cyc, ill, done);
        tests_run++;
        if (!done || cyc != 2 || ill != 1) begin
            fails++; $display("FAIL b_bne_illegal got done=%0b cyc=%0d ill=%0d want 1 2 1", done, cyc, ill);
        end
        tests_run++;
        if (b_retired !== exp_ret_b) begin
            fails++; $display("FAIL b_bne_retired got %0d want %0d", b_retired, exp_ret_b);
        end
        for (int k = 0; k < 17; k++) begin
            ins = $urandom;
            ins[6:0] = 7'b0010011; ins[14:12] = 3'b000;
            run_b(ins, cyc, ill, done);
            exp_ret_b = exp_ret_b + 4'd1;
            tests_run++;
            if (!done || cyc != 4) begin
                fails++; $display("FAIL b_addi_%0d got done=%0b cyc=%0d want 1 4", k, done, cyc);
            end
        end
        tests_run++;
        if (b_retired !== 4'd1) begin
            fails++; $display("FAIL b_wrap got %0d want 1", b_retired);
        end
        rst_b = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_add();
        bit done;
        run_a(I_ADD, 0, 0, 1'b0, 1'b0, done);
        exp_ret = exp_ret + 1;
        tests_run++;
        if (!done || ob_n != 4 || {ob_state[0], ob_state[1], ob_state[2], ob_state[3]} !== 16'h0168) begin
            fails++; $display("FAIL add_states got n=%0d %0h%0h%0h%0h want 4 0168", ob_n,
                ob_state[0], ob_state[1], ob_state[2], ob_state[3]);
        end
        tests_run++;
        if (ob_alu[2] !== 4'b0000 || ob_rw[3] !== 1'b1) begin
            fails++; $display("FAIL add_ctl got alu=%0b regwen=%0b want 0000 1", ob_alu[2], ob_rw[3]);
        end
        tests_run++;
        if (retired !== exp_ret) begin
            fails++; $display("FAIL add_retired got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_lw_wait();
        bit done;
        int cnt;
        run_a(I_LW, 0, 3, 1'b0, 1'b0, done);
        exp_ret = exp_ret + 1;
        cnt = 0;
        for (int i = 0; i < ob_n; i++) if (ob_mdr[i]) cnt++;
        tests_run++;
        if (!done || ob_n != 8) begin
            fails++; $display("FAIL lw_cycles got done=%0b n=%0d want 1 8", done, ob_n);
        end
        tests_run++;
        if (cnt != 1 || ob_mdr[6] !== 1'b1 || ob_state[6] !== 4'd3) begin
            fails++; $display("FAIL lw_mdrwrite got cnt=%0d at6=%0b st6=%0d want 1 1 3", cnt, ob_mdr[6], ob_state[6]);
        end
        tests_run++;
        if (retired !== exp_ret) begin
            fails++; $display("FAIL lw_retired got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        bit done;
        run_a(I_BNE, 0, 0, 1'b0, 1'b0, done);
        tests_run++;
        if (!done || ob_state[2] !== 4'd9 || ob_pcw[2] !== 1'b1) begin
            fails++; $display("FAIL bne_taken got st=%0d pcwrite=%0b want 9 1", ob_state[2], ob_pcw[2]);
        end
        run_a(I_BNE, 0, 0, 1'b1, 1'b0, done);
        tests_run++;
        if (!done || ob_state[2] !== 4'd9 || ob_pcw[2] !== 1'b0) begin
            fails++; $display("FAIL bne_not_taken got st=%0d pcwrite=%0b want 9 0", ob_state[2], ob_pcw[2]);
        end
        exp_ret = exp_ret + 2;
        tests_run++;
        if (retired !== exp_ret) begin
            fails++; $display("FAIL bne_retired got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_itype();
        bit done;
        run_a(I_SRAI, 0, 0, 1'b0, 1'b0, done);
        tests_run++;
        if (!done || ob_state[2] !== 4'd7 || ob_alu[2] !== 4'b1011 || ob_bsel[2] !== 1'b1) begin
            fails++; $display("FAIL srai got st=%0d alu=%0b bsel=%0b want 7 1011 1", ob_state[2], ob_alu[2], ob_bsel[2]);
        end
        run_a(I_ADDI, 0, 0, 1'b0, 1'b0, done);
        tests_run++;
        if (!done || ob_state[2] !== 4'd7 || ob_alu[2] !== 4'b0000 || ob_bsel[2] !== 1'b1) begin
            fails++; $display("FAIL addi got st=%0d alu=%0b bsel=%0b want 7 0000 1", ob_state[2], ob_alu[2], ob_bsel[2]);
        end
        exp_ret = exp_ret + 2;
    endtask

    function automatic bit legal_op(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 ||
               op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111;
    endfunction

    // Kinds: 0 LW, 1 SW, 2 R, 3 I, 4 BR, 5 JAL, 6 JALR, 7 illegal
    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [3:0]  exp_alu;
        int kind, fw, mw, lat, e_pcw, e_rw, e_mdr, e_ill, e_st, n_pcw, n_rw, n_mdr, n_ill, n_st, idx;
        bit done, z, l, taken;
        int base [8] = '{5, 4, 4, 4, 3, 3, 3, 2};
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 7);
            fw = $urandom_range(0, 4); mw = $urandom_range(0, 4);
            z = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
            ins = $urandom;
            case (kind)
                0: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'b010; end
                1: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'b010; end
                2: ins[6:0] = 7'b0110011;
                3: ins[6:0] = 7'b0010011;
                4: begin
                    ins[6:0] = 7'b1100011;
                    case ($urandom_range(0, 3))
                        0: ins[14:12] = 3'b000; 1: ins[14:12] = 3'b001;
                        2: ins[14:12] = 3'b100; default: ins[14:12] = 3'b101;
                    endcase
                end
                5: ins[6:0] = 7'b1101111;
                6: begin ins[6:0] = 7'b1100111; ins[14:12] = 3'b000; end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        op = 7'($urandom);
                        while (legal_op(op)) op = 7'($urandom);
                        ins[6:0] = op;
                    end else begin
                        ins[6:0] = 7'b1100011;
                        ins[14:12] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b110;
                        ins[12] = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            f3 = ins[14:12];
            taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? l : !l;
            lat   = base[kind] + fw + ((kind <= 1) ? mw : 0);
            e_pcw = 1 + ((kind == 4) ? int'(taken) : (kind == 5 || kind == 6) ? 1 : 0);
            e_rw  = (kind == 0 || kind == 2 || kind == 3 || kind == 5 || kind == 6) ? 1 : 0;
            e_mdr = (kind == 0) ? 1 : 0;
            e_ill = (kind == 7) ? 1 : 0;
            e_st  = (kind == 1) ? mw + 1 : 0;
            exp_alu = (kind == 2 || f3 == 3'b101) ? {f3, ins[30]} : {f3, 1'b0};
            run_a(ins, fw, mw, z, l, done);
            if (kind != 7) exp_ret = exp_ret + 1;
            n_pcw = 0; n_rw = 0; n_mdr = 0; n_ill = 0; n_st = 0; idx = -1;
            for (int i = 0; i < ob_n; i++) begin
                n_pcw += int'(ob_pcw[i]); n_rw += int'(ob_rw[i]); n_mdr += int'(ob_mdr[i]);
                n_ill += int'(ob_ill[i]); n_st += int'(ob_st[i]);
                if (ob_state[i] == 4'd6 || ob_state[i] == 4'd7) idx = i;
            end
            tests_run++;
            if (!done || ob_n != lat) begin
                fails++; $display("FAIL rnd%0d_latency ins=%08h got done=%0b n=%0d want %0d", it, ins, done, ob_n, lat);
            end
            tests_run++;
            if ({n_pcw, n_rw, n_mdr, n_ill, n_st} != {e_pcw, e_rw, e_mdr, e_ill, e_st}) begin
                fails++; $display("FAIL rnd%0d_ctl ins=%08h got pcw=%0d rw=%0d mdr=%0d ill=%0d st=%0d want %0d %0d %0d %0d %0d",
                    it, ins, n_pcw, n_rw, n_mdr, n_ill, n_st, e_pcw, e_rw, e_mdr, e_ill, e_st);
            end
            tests_run++;
            if (retired !== exp_ret) begin
                fails++; $display("FAIL rnd%0d_retired got %0d want %0d", it, retired, exp_ret);
            end
            if (kind == 2 || kind == 3) begin
                tests_run++;
                if (idx < 0 || ob_alu[idx] !== exp_alu) begin
                    fails++; $display("FAIL rnd%0d_alusel ins=%08h got %0b want %0b", it, ins,
                        (idx < 0) ? 4'hx : ob_alu[idx], exp_alu);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        instr = I_LW; zero = 1'b0; lt = 1'b0;
        c = 0;
        while (state_dbg != 4'd3 && c < 20) begin
            mem_ready = (state_dbg == 4'd0);
            @(posedge clk); #1; c++;
        end
        tests_run++;
        if (state_dbg !== 4'd3) begin
            fails++; $display("FAIL rstmid_reach got st=%0d want 3", state_dbg);
        end
        mem_ready = 1'b1; rst = 1'b1;
        #1;
        exp_ret = '0;
        tests_run++;
        if ({mdrwrite, mem_req, regwen, state_dbg} !== 7'h0 || retired !== exp_ret) begin
            fails++; $display("FAIL rstmid got mdr=%0b req=%0b st=%0d ret=%0d want 0 0 0 0",
                mdrwrite, mem_req, state_dbg, retired);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int c;
        instr = I_ADD; mem_ready = 1'b0;
        c = 0;
        while (state_dbg != 4'd12 && c < 40) begin
            @(posedge clk); #1; c++;
        end
        tests_run++;
        if (state_dbg !== 4'd12 || c != MAXW + 1) begin
            fails++; $display("FAIL timeout_entry got st=%0d cycles=%0d want 12 %0d", state_dbg, c, MAXW + 1);
        end
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (timeout !== 1'b1 || state_dbg !== 4'd12) begin
            fails++; $display("FAIL timeout_sticky got to=%0b st=%0d want 1 12", timeout, state_dbg);
        end
        tests_run++;
        if ({mem_req, pcwrite, irwrite, regwen, illegal, wbsel, immsel, asel, bsel, alusel} !==
            {5'b0, 2'd2, 2'd2, 2'd0, 1'b0, 4'd0}) begin
            fails++; $display("FAIL trap_defaults got %04h want %04h",
                {mem_req, pcwrite, irwrite, regwen, illegal, wbsel, immsel, asel, bsel, alusel},
                {5'b0, 2'd2, 2'd2, 2'd0, 1'b0, 4'd0});
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (state_dbg !== 4'd0 || timeout !== 1'b0) begin
            fails++; $display("FAIL trap_reset got st=%0d to=%0b want 0 0", state_dbg, timeout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_b_ext0_and_wrap();
        test_add();
        test_lw_wait();
        test_branch();
        test_itype();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
